axi4_lite_regfile: RTL and testbench



---
 rtl/axi4_lite_regfile_if.sv | 34 +++
 rtl/axi4_lite_regfile.sv | 186 ++++++++++++++++++
 tb/tb_axi4_lite_regfile.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle for the generic register file: the five channels
// grouped with master (interconnect side) and slave (register file side) views.
interface axi4_lite_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite slave register file. Byte-lane writes via WSTRB,
// AW and W accepted independently in either order, out-of-range accesses
// answered with SLVERR. Read and write channels run as independent FSMs.
module axi4_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    axi4_lite_regfile_if.slave s_axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);
    // One past the last valid byte address; widened so the compare cannot wrap.
    localparam logic [ADDR_WIDTH:0] LIMIT  = (ADDR_WIDTH + 1)'(NUM_REGS * BYTES);
    localparam logic [1:0]          OKAY   = 2'b00;
    localparam logic [1:0]          SLVERR = 2'b10;

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

    // Write channel state
    w_state_t              w_state_reg;
    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [BYTES-1:0]      wstrb_reg;

    // Read channel state
    r_state_t              r_state_reg;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Effective write transaction: a handshake this cycle overrides the held copy
    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] waddr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [BYTES-1:0]      wstrb_next;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;

    logic                  ar_hs;
    logic                  r_in_range;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Merge held and in-flight AW/W so a write commits on the edge the second half arrives
    always_comb begin
        aw_hs      = (w_state_reg == W_ACCEPT) && s_axi.AWVALID && awready_reg;
        w_hs       = (w_state_reg == W_ACCEPT) && s_axi.WVALID && wready_reg;
        waddr_next = aw_hs ? s_axi.AWADDR : awaddr_reg;
        wdata_next = w_hs ? s_axi.WDATA : wdata_reg;
        wstrb_next = w_hs ? s_axi.WSTRB : wstrb_reg;
        commit     = (w_state_reg == W_ACCEPT) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
        w_in_range = ({1'b0, waddr_next} < LIMIT);
        w_idx      = waddr_next[OFFS +: IDX_W];
    end

    // Read address decode straight off the AR channel
    always_comb begin
        ar_hs      = (r_state_reg == R_ACCEPT) && s_axi.ARVALID && arready_reg;
        r_in_range = ({1'b0, s_axi.ARADDR} < LIMIT);
        r_idx      = s_axi.ARADDR[OFFS +: IDX_W];
    end

    // Storage split per byte lane so each WSTRB bit gates its own array
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [7:0] lane_reg [NUM_REGS];

        // Lane write on commit; reset clears every register
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    lane_reg[r] <= 8'h00;
                end
            end else if (commit && w_in_range && wstrb_next[gi]) begin
                lane_reg[w_idx] <= wdata_next[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_reg[r_idx];
    end

    // Write FSM: collect AW and W in any order, commit, then hold B until accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_reg <= W_ACCEPT;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= OKAY;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            case (w_state_reg)
                W_ACCEPT: begin
                    if (aw_hs) begin
                        awaddr_reg  <= s_axi.AWADDR;
                        aw_held_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_reg  <= s_axi.WDATA;
                        wstrb_reg  <= s_axi.WSTRB;
                        w_held_reg <= 1'b1;
                    end
                    if (commit) begin
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= w_in_range ? OKAY : SLVERR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        w_state_reg <= W_RESP;
                    end else begin
                        awready_reg <= !(aw_held_reg || aw_hs);
                        wready_reg  <= !(w_held_reg || w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        bvalid_reg  <= 1'b0;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_ACCEPT;
                    end
                end
                default: w_state_reg <= W_ACCEPT;
            endcase
        end
    end

    // Read FSM: capture the pre-commit register value on AR, hold R until accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_reg <= R_ACCEPT;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= OKAY;
            rdata_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_ACCEPT: begin
                    arready_reg <= 1'b1;
                    if (ar_hs) begin
                        rdata_reg   <= r_in_range ? rd_word : '0;
                        rresp_reg   <= r_in_range ? OKAY : SLVERR;
                        rvalid_reg  <= 1'b1;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.RREADY) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_ACCEPT;
                    end
                end
                default: r_state_reg <= R_ACCEPT;
            endcase
        end
    end

    assign s_axi.AWREADY = awready_reg;
    assign s_axi.WREADY  = wready_reg;
    assign s_axi.BVALID  = bvalid_reg;
    assign s_axi.BRESP   = bresp_reg;
    assign s_axi.ARREADY = arready_reg;
    assign s_axi.RVALID  = rvalid_reg;
    assign s_axi.RRESP   = rresp_reg;
    assign s_axi.RDATA   = rdata_reg;
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed testbench for axi4_lite_regfile (32 x 32-bit configuration).
module tb_axi4_lite_regfile;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 32;

    logic ACLK = 1'b0;
    logic ARESETN;
    int   checks = 0;
    int   errors = 0;

    axi4_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_regfile #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR)
    ) dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .s_axi  (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Drive AW and W together; returns once both handshakes are done (bounded)
    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output bit ok);
        logic aw_go, w_go;
        bus.AWADDR  = addr;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        for (int cyc = 0; cyc < 16 && (bus.AWVALID || bus.WVALID); cyc++) begin
            aw_go = bus.AWVALID && bus.AWREADY;
            w_go  = bus.WVALID && bus.WREADY;
            tick();
            if (aw_go) bus.AWVALID = 1'b0;
            if (w_go)  bus.WVALID  = 1'b0;
        end
        ok = !(bus.AWVALID || bus.WVALID);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
    endtask

    // Wait for BVALID (bounded) and accept the response
    task automatic take_b(output logic [1:0] resp, output bit ok);
        for (int cyc = 0; cyc < 16 && !bus.BVALID; cyc++) tick();
        ok   = bus.BVALID;
        resp = bus.BRESP;
        if (ok) begin
            bus.BREADY = 1'b1;
            tick();
            bus.BREADY = 1'b0;
        end
        $display("B   resp=%b ok=%0d", resp, ok);
    endtask

    // Full write: returns response and whether BVALID was up right after the last handshake
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic bv_now, output bit ok);
        bit ok_a, ok_b;
        issue_write(addr, data, strb, ok_a);
        bv_now = bus.BVALID;
        take_b(resp, ok_b);
        ok = ok_a && ok_b;
        $display("WR  addr=%h data=%h strb=%h resp=%b", addr, data, strb, resp);
    endtask

    // Full read: returns data/response and whether RVALID was up the cycle after AR
    task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic rv_now, output bit ok);
        logic ar_go;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        for (int cyc = 0; cyc < 16 && bus.ARVALID; cyc++) begin
            ar_go = bus.ARREADY;
            tick();
            if (ar_go) bus.ARVALID = 1'b0;
        end
        ok          = !bus.ARVALID;
        bus.ARVALID = 1'b0;
        rv_now      = bus.RVALID;
        for (int cyc = 0; cyc < 16 && !bus.RVALID; cyc++) tick();
        ok   = ok && bus.RVALID;
        data = bus.RDATA;
        resp = bus.RRESP;
        if (bus.RVALID) begin
            bus.RREADY = 1'b1;
            tick();
            bus.RREADY = 1'b0;
        end
        $display("RD  addr=%h data=%h resp=%b", addr, data, resp);
    endtask

    task automatic test_reset();
        ARESETN     = 1'b0;
        bus.AWADDR  = '0; bus.AWVALID = 1'b0;
        bus.WDATA   = '0; bus.WSTRB   = '0; bus.WVALID = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARADDR  = '0; bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
             bus.BRESP, bus.RRESP, bus.RDATA} !== '0) begin
            $display("FAIL reset_outputs: got aw=%b w=%b ar=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h want all 0",
                     bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                     bus.BRESP, bus.RRESP, bus.RDATA);
            errors++;
        end
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            $display("FAIL ready_after_reset: got %b want 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
            errors++;
        end
    endtask

    task automatic test_full_write();
        logic [1:0]  resp;
        logic [31:0] data;
        logic        now;
        bit          ok;
        write_txn(32'h08, 32'hDEADBEEF, 4'hF, resp, now, ok);
        checks++;
        if (!ok || now !== 1'b1 || resp !== 2'b00) begin
            $display("FAIL full_write: got ok=%0d bvalid_next=%b bresp=%b want 1 1 00", ok, now, resp);
            errors++;
        end
        read_txn(32'h08, data, resp, now, ok);
        checks++;
        if (!ok || now !== 1'b1 || data !== 32'hDEADBEEF || resp !== 2'b00) begin
            $display("FAIL full_read: got ok=%0d rvalid_next=%b rdata=%h rresp=%b want 1 1 deadbeef 00",
                     ok, now, data, resp);
            errors++;
        end
    endtask

    task automatic test_data_first();
        logic [1:0]  resp;
        logic [31:0] data;
        logic        now;
        bit          ok;
        write_txn(32'h10, 32'hAABBCCDD, 4'hF, resp, now, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin
            $display("FAIL preload_reg4: got ok=%0d bresp=%b want 1 00", ok, resp);
            errors++;
        end
        // W first
        checks++;
        if (bus.WREADY !== 1'b1) begin
            $display("FAIL wready_idle: got %b want 1", bus.WREADY);
            errors++;
        end
        bus.WDATA  = 32'h11223344;
        bus.WSTRB  = 4'h5;
        bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        $display("W   data=%h strb=%h (address pending)", bus.WDATA, bus.WSTRB);
        checks++;
        if ({bus.WREADY, bus.AWREADY, bus.BVALID} !== 3'b010) begin
            $display("FAIL w_held: got wready/awready/bvalid=%b want 010",
                     {bus.WREADY, bus.AWREADY, bus.BVALID});
            errors++;
        end
        tick();
        checks++;
        if (bus.BVALID !== 1'b0) begin
            $display("FAIL no_early_b: got bvalid=%b want 0", bus.BVALID);
            errors++;
        end
        tick();
        bus.AWADDR  = 32'h10;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) begin
            $display("FAIL b_after_aw: got bvalid=%b bresp=%b want 1 00", bus.BVALID, bus.BRESP);
            errors++;
        end
        take_b(resp, ok);
        checks++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
            $display("FAIL ready_after_b: got awready=%b wready=%b want 1 1", bus.AWREADY, bus.WREADY);
            errors++;
        end
        read_txn(32'h10, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'hAA22CC44 || resp !== 2'b00) begin
            $display("FAIL strobe_merge: got ok=%0d rdata=%h rresp=%b want 1 aa22cc44 00", ok, data, resp);
            errors++;
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] data;
        logic        now;
        bit          ok;
        write_txn(32'h80, 32'hFFFFFFFF, 4'hF, resp, now, ok);
        checks++;
        if (!ok || now !== 1'b1 || resp !== 2'b10) begin
            $display("FAIL oor_write: got ok=%0d bvalid_next=%b bresp=%b want 1 1 10", ok, now, resp);
            errors++;
        end
        read_txn(32'h00, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'h0 || resp !== 2'b00) begin
            $display("FAIL oor_no_alias: got rdata=%h rresp=%b want 00000000 00", data, resp);
            errors++;
        end
        read_txn(32'h08, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'hDEADBEEF) begin
            $display("FAIL oor_reg2_kept: got rdata=%h want deadbeef", data);
            errors++;
        end
        read_txn(32'h80, data, resp, now, ok);
        checks++;
        if (!ok || now !== 1'b1 || data !== 32'h0 || resp !== 2'b10) begin
            $display("FAIL oor_read: got rvalid_next=%b rdata=%h rresp=%b want 1 00000000 10", now, data, resp);
            errors++;
        end
        read_txn(32'h7C, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'h0 || resp !== 2'b00) begin
            $display("FAIL last_reg_read: got rdata=%h rresp=%b want 00000000 00", data, resp);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        issue_write(32'h0C, 32'h12345678, 4'hF, ok);
        checks++;
        if (!ok) begin
            $display("FAIL bp_write_issue: got handshake timeout want accepted");
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== 5'b10000) begin
                $display("FAIL bp_b_hold: cycle %0d got bvalid/bresp/awready/wready=%b want 10000",
                         i, {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY});
                errors++;
            end
            tick();
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        $display("B   resp accepted after 5 stall cycles");
        checks++;
        if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
            $display("FAIL bp_b_release: got bvalid/awready/wready=%b want 011",
                     {bus.BVALID, bus.AWREADY, bus.WREADY});
            errors++;
        end
        bus.ARADDR  = 32'h0C;
        bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h12345678 || bus.RRESP !== 2'b00 ||
                bus.ARREADY !== 1'b0) begin
                $display("FAIL bp_r_hold: cycle %0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 12345678 00 0",
                         i, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY);
                errors++;
            end
            tick();
        end
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        $display("RD  addr=0000000c accepted after 4 stall cycles");
        checks++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
            $display("FAIL bp_r_release: got rvalid=%b arready=%b want 0 1", bus.RVALID, bus.ARREADY);
            errors++;
        end
    endtask

    task automatic test_collision();
        logic [1:0]  resp;
        logic [31:0] data;
        logic        now;
        bit          ok;
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            $display("FAIL coll_idle_ready: got %b want 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
            errors++;
        end
        bus.AWADDR  = 32'h04;
        bus.WDATA   = 32'h00000055;
        bus.WSTRB   = 4'hF;
        bus.ARADDR  = 32'h04;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        bus.ARVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b1 || bus.RVALID !== 1'b1 || bus.RDATA !== 32'h0 || bus.RRESP !== 2'b00) begin
            $display("FAIL coll_same_edge: got bvalid=%b rvalid=%b rdata=%h rresp=%b want 1 1 00000000 00",
                     bus.BVALID, bus.RVALID, bus.RDATA, bus.RRESP);
            errors++;
        end
        take_b(resp, ok);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        $display("RD  addr=00000004 (same edge as commit) accepted");
        read_txn(32'h04, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'h00000055 || resp !== 2'b00) begin
            $display("FAIL coll_after: got rdata=%h rresp=%b want 00000055 00", data, resp);
            errors++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0]  resp;
        logic [31:0] data;
        logic        now;
        bit          ok;
        bus.AWADDR  = 32'h00;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        $display("AW  addr=00000000 (data pending)");
        checks++;
        if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b1) begin
            $display("FAIL aw_held: got awready=%b wready=%b want 0 1", bus.AWREADY, bus.WREADY);
            errors++;
        end
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
             bus.BRESP, bus.RRESP, bus.RDATA} !== '0) begin
            $display("FAIL async_reset: got aw=%b w=%b ar=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h want all 0",
                     bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                     bus.BRESP, bus.RRESP, bus.RDATA);
            errors++;
        end
        tick();
        ARESETN = 1'b1;
        tick();
        bus.WDATA  = 32'hCAFEF00D;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        $display("W   data=cafef00d after reset (no address)");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.BVALID !== 1'b0) begin
                $display("FAIL no_b_after_reset: cycle %0d got bvalid=%b want 0", i, bus.BVALID);
                errors++;
            end
            tick();
        end
        read_txn(32'h00, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'h0 || resp !== 2'b00) begin
            $display("FAIL reg0_after_reset: got rdata=%h rresp=%b want 00000000 00", data, resp);
            errors++;
        end
        read_txn(32'h08, data, resp, now, ok);
        checks++;
        if (!ok || data !== 32'h0) begin
            $display("FAIL reg2_cleared: got rdata=%h want 00000000", data);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_data_first();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
